imem_responder: RTL and testbench

- Responder (slave) end of the core's instruction-fetch request/response protocol: ireq valid/ready/hpl/addr in, irsp valid/ready/rerr/data out.
- Holds a word-addressed synchronous instruction RAM, a backdoor load port, an outstanding-request counter and a response FIFO.
- Used as the fetch memory in core-level simulation and FPGA builds; supports full-throughput pipelined fetch with arbitrary response backpressure.

---
 rtl/mem_if_pkg.sv | 15 +
 rtl/rsp_fifo.sv | 74 +++++++
 rtl/imem_responder.sv | 123 ++++++++++++
 tb/tb_imem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the instruction-fetch request/response interface:
// hart privilege level encodings and the response FIFO entry width.
package mem_if_pkg;

    typedef enum logic [1:0] {
        HPL_U    = 2'b00,
        HPL_S    = 2'b01,
        HPL_RSVD = 2'b10,
        HPL_M    = 2'b11
    } hpl_e;

    // One response entry: {rerr, data[31:0]}
    localparam int RSP_ENTRY_W = 1 + 32;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO whose head entry sits in output registers, so consumers
// see glitch-free valid/data. Pointers carry one extra wrap bit.
module rsp_fifo #(
    parameter int C_WIDTH   = 33,
    parameter int C_DEPTH_X = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               i_en,
    input  logic               i_push,
    input  logic [C_WIDTH-1:0] i_push_data,
    input  logic               i_pop,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_head_valid,
    output logic [C_WIDTH-1:0] o_head_data
);

    localparam int                 C_DEPTH   = 2 ** C_DEPTH_X;
    localparam logic [C_DEPTH_X:0] C_PTR_ONE = 1;

    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic [C_DEPTH_X:0] r_wr_ptr;
    logic [C_DEPTH_X:0] r_rd_ptr;
    logic [C_DEPTH_X:0] w_wr_next;
    logic [C_DEPTH_X:0] w_rd_next;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               r_head_valid;
    logic [C_WIDTH-1:0] r_head_data;
    logic [C_WIDTH-1:0] w_head_next;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[C_DEPTH_X] != r_rd_ptr[C_DEPTH_X]) &&
                     (r_wr_ptr[C_DEPTH_X-1:0] == r_rd_ptr[C_DEPTH_X-1:0]);

    assign w_pop_ok  = i_en & i_pop & !o_empty;
    assign w_push_ok = i_en & i_push & (!o_full | w_pop_ok);

    always_comb begin
        w_wr_next   = w_push_ok ? r_wr_ptr + C_PTR_ONE : r_wr_ptr;
        w_rd_next   = w_pop_ok  ? r_rd_ptr + C_PTR_ONE : r_rd_ptr;
        // The next head may be the entry being written this very cycle
        if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
            w_head_next = i_push_data;
        end else begin
            w_head_next = r_mem[w_rd_next[C_DEPTH_X-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[C_DEPTH_X-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else if (i_en) begin
            r_wr_ptr     <= w_wr_next;
            r_rd_ptr     <= w_rd_next;
            r_head_valid <= (w_wr_next != w_rd_next);
            r_head_data  <= w_head_next;
        end
    end

    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: synchronous instruction RAM with backdoor load,
// outstanding-request accounting and an in-order response FIFO.
module imem_responder
    import mem_if_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDR   = 32'h0,
    parameter int          C_DEPTH_X     = 10,
    parameter int          C_RSP_DEPTH_X = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clk_en_i,
    output logic                 ireqready_o,
    input  logic                 ireqvalid_i,
    input  logic [1:0]           ireqhpl_i,
    input  logic [31:0]          ireqaddr_i,
    input  logic                 irspready_i,
    output logic                 irspvalid_o,
    output logic                 irsprerr_o,
    output logic [31:0]          irspdata_o,
    input  logic                 ldwr_i,
    input  logic [C_DEPTH_X-1:0] ldaddr_i,
    input  logic [31:0]          lddata_i
);

    localparam int                     C_WORDS   = 2 ** C_DEPTH_X;
    localparam logic [32:0]            C_SPAN    = 33'd4 << C_DEPTH_X;
    localparam logic [C_RSP_DEPTH_X:0] C_CNT_MAX = (C_RSP_DEPTH_X + 1)'(2 ** C_RSP_DEPTH_X);
    localparam logic [C_RSP_DEPTH_X:0] C_CNT_ONE = 1;

    logic [31:0]              r_ram [C_WORDS];
    logic [31:0]              r_rd_data;
    logic                     r_rd_valid;
    logic                     r_rd_err;
    logic [C_RSP_DEPTH_X:0]   r_count;

    logic [31:0]              w_off;
    logic [C_DEPTH_X-1:0]     w_idx;
    logic                     w_err;
    logic                     w_accept;
    logic                     w_pop;
    logic [RSP_ENTRY_W-1:0]   w_push_data;
    logic [RSP_ENTRY_W-1:0]   w_head_data;
    logic                     w_head_valid;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;

    // Offset wraps below the base, so such addresses fall out of range too
    assign w_off = ireqaddr_i - C_BASE_ADDR;
    assign w_idx = w_off[C_DEPTH_X+1:2];
    assign w_err = (ireqaddr_i[1:0] != 2'b00) |
                   ({1'b0, w_off} >= C_SPAN) |
                   (ireqhpl_i == HPL_RSVD);

    assign ireqready_o = !reset_i & (r_count < C_CNT_MAX);
    assign w_accept    = ireqvalid_i & ireqready_o & clk_en_i;
    assign w_pop       = irspvalid_o & irspready_i & clk_en_i;

    // Read-first RAM: a same-cycle backdoor write is not seen by the fetch
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            if (ldwr_i) begin
                r_ram[ldaddr_i] <= lddata_i;
            end
            if (w_accept) begin
                r_rd_data <= r_ram[w_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else if (clk_en_i) begin
            r_rd_valid <= w_accept;
            if (w_accept) begin
                r_rd_err <= w_err;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clk_en_i) begin
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_push_data = {r_rd_err, r_rd_err ? 32'h0 : r_rd_data};

    rsp_fifo #(
        .C_WIDTH   (RSP_ENTRY_W),
        .C_DEPTH_X (C_RSP_DEPTH_X)
    ) u_rsp_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .i_en         (clk_en_i),
        .i_push       (r_rd_valid),
        .i_push_data  (w_push_data),
        .i_pop        (w_pop),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data)
    );

    assign irspvalid_o = w_head_valid;
    assign irsprerr_o  = w_head_data[RSP_ENTRY_W-1];
    assign irspdata_o  = w_head_data[31:0];

    // The outstanding count keeps the FIFO from ever being pushed while full
    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(w_fifo_full && r_rd_valid && clk_en_i && !w_pop));
    a_head_tracks_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        (w_head_valid == !w_fifo_empty));

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus pushes expected responses,
// an independent monitor pops and compares on every response handshake.
module tb_imem_responder;
    import mem_if_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        ireqready_o;
    logic        ireqvalid_i;
    logic [1:0]  ireqhpl_i;
    logic [31:0] ireqaddr_i;
    logic        irspready_i;
    logic        irspvalid_o;
    logic        irsprerr_o;
    logic [31:0] irspdata_o;
    logic        ldwr_i;
    logic [9:0]  ldaddr_i;
    logic [31:0] lddata_i;

    always #5 clk_i = ~clk_i;

    imem_responder #(
        .C_BASE_ADDR   (32'h0),
        .C_DEPTH_X     (10),
        .C_RSP_DEPTH_X (2)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (clk_en_i),
        .ireqready_o (ireqready_o),
        .ireqvalid_i (ireqvalid_i),
        .ireqhpl_i   (ireqhpl_i),
        .ireqaddr_i  (ireqaddr_i),
        .irspready_i (irspready_i),
        .irspvalid_o (irspvalid_o),
        .irsprerr_o  (irsprerr_o),
        .irspdata_o  (irspdata_o),
        .ldwr_i      (ldwr_i),
        .ldaddr_i    (ldaddr_i),
        .lddata_i    (lddata_i)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          acc_cyc;
        bit          exact;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!reset_i && clk_en_i && irspvalid_o && irspready_i) begin
                $display("rsp cyc=%0d rerr=%0d data=%h", cyc, irsprerr_o, irspdata_o);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: actual rerr=%0d data=%h required none",
                             irsprerr_o, irspdata_o);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp", {31'b0, irsprerr_o, irspdata_o}, {31'b0, e.err, e.data});
                    if (e.exact) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
                end
            end
        end
    end

    task automatic req(input logic [31:0] addr, input logic [1:0] hpl, input logic exp_err,
                       input logic [31:0] exp_data, input bit exact, output int waits);
        waits       = 0;
        ireqvalid_i = 1'b1;
        ireqaddr_i  = addr;
        ireqhpl_i   = hpl;
        while (1) begin
            @(negedge clk_i);
            if (ireqready_o && clk_en_i) break;
            waits++;
            if (waits >= 100) begin
                n_checks++;
                $display("FAIL req_timeout: addr %h not accepted within 100 cycles", addr);
                ireqvalid_i = 1'b0;
                return;
            end
        end
        sb_q.push_back('{exp_err, exp_data, cyc, exact});
        $display("req cyc=%0d addr=%h hpl=%0d", cyc, addr, hpl);
        @(posedge clk_i); #1;
        ireqvalid_i = 1'b0;
    endtask

    task automatic ld(input logic [9:0] idx, input logic [31:0] data);
        ldwr_i = 1'b1; ldaddr_i = idx; lddata_i = data;
        @(posedge clk_i); #1;
        ldwr_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk_i);
            t++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(negedge clk_i);
        check("idle_valid", 64'(irspvalid_o), 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        reset_i = 1'b1; clk_en_i = 1'b1; ireqvalid_i = 1'b0; ireqaddr_i = '0;
        ireqhpl_i = HPL_U; irspready_i = 1'b0; ldwr_i = 1'b0; ldaddr_i = '0; lddata_i = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 64'(irspvalid_o), 64'd0);
        check("rst_rerr",  64'(irsprerr_o),  64'd0);
        check("rst_data",  64'(irspdata_o),  64'd0);
        check("rst_ready", 64'(ireqready_o), 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_rst", 64'(ireqready_o), 64'd1);
        @(posedge clk_i); #1;

        for (int i = 0; i < 4; i++) ld(10'(i), 32'h11111111 * (i + 1));
        ld(10'd5, 32'hCAFEF00D);

        // Back-to-back fetches, fixed 2-cycle latency, ready never drops
        irspready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req(32'(i * 4), HPL_M, 1'b0, 32'h11111111 * (i + 1), 1'b1, w);
            check("b2b_no_stall", 64'(w), 64'd0);
        end
        drain();

        // Error responses: misaligned, out of range, reserved privilege
        req(32'h2,    HPL_U,    1'b1, 32'h0, 1'b1, w);
        req(32'h1000, HPL_S,    1'b1, 32'h0, 1'b1, w);
        req(32'h0,    HPL_RSVD, 1'b1, 32'h0, 1'b1, w);
        drain();

        // Backpressure: four outstanding fill the window
        irspready_i = 1'b0;
        for (int i = 0; i < 4; i++) req(32'(i * 4), HPL_U, 1'b0, 32'h11111111 * (i + 1), 1'b0, w);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("full_ready", 64'(ireqready_o), 64'd0);
        check("full_count", 64'(dut.r_count), 64'd4);
        @(posedge clk_i); #1;
        irspready_i = 1'b1;
        @(negedge clk_i);
        check("pop_cycle_ready", 64'(ireqready_o), 64'd0);
        @(posedge clk_i); #1;
        irspready_i = 1'b0;
        @(negedge clk_i);
        check("after_pop_ready", 64'(ireqready_o), 64'd1);
        @(posedge clk_i); #1;
        irspready_i = 1'b1;
        drain();

        // Backdoor write colliding with a fetch of the same word: read-first
        ldwr_i = 1'b1; ldaddr_i = 10'd5; lddata_i = 32'hDEADBEEF;
        req(32'h14, HPL_M, 1'b0, 32'hCAFEF00D, 1'b1, w);
        ldwr_i = 1'b0;
        req(32'h14, HPL_M, 1'b0, 32'hDEADBEEF, 1'b1, w);
        drain();

        // Clock enable low for three cycles with a response at the head
        req(32'h0, HPL_M, 1'b0, 32'h11111111, 1'b0, w);
        req(32'h4, HPL_M, 1'b0, 32'h22222222, 1'b0, w);
        clk_en_i = 1'b0;
        ireqvalid_i = 1'b1; ireqaddr_i = 32'h8; ireqhpl_i = HPL_M;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("freeze_outputs", {29'b0, irspvalid_o, irsprerr_o, irspdata_o, ireqready_o},
                  {29'b0, 1'b1, 1'b0, 32'h11111111, 1'b1});
            check("freeze_count", 64'(dut.r_count), 64'd2);
        end
        @(posedge clk_i); #1;
        clk_en_i = 1'b1;
        req(32'h8, HPL_M, 1'b0, 32'h33333333, 1'b0, w);
        req(32'hC, HPL_M, 1'b0, 32'h44444444, 1'b0, w);
        drain();

        // Reset with three responses outstanding; RAM survives
        irspready_i = 1'b0;
        for (int i = 0; i < 3; i++) req(32'(i * 4), HPL_U, 1'b0, 32'h11111111 * (i + 1), 1'b0, w);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        sb_q.delete();
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("midrst_valid", 64'(irspvalid_o), 64'd0);
        check("midrst_count", 64'(dut.r_count), 64'd0);
        check("midrst_ready", 64'(ireqready_o), 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        irspready_i = 1'b1;
        req(32'h0, HPL_M, 1'b0, 32'h11111111, 1'b1, w);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
